// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: stage-boundary bundle, control and statistics signals
interface pipe_stage_reg_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             stall;
  logic             flush;
  logic             valid_in;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             valid_out;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  modport master (output stall, flush, valid_in, d, input q, valid_out, stall_cnt, flush_cnt);
  modport slave  (input stall, flush, valid_in, d, output q, valid_out, stall_cnt, flush_cnt);
endinterface

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: load/stall/flush pipeline register; PIPE_REG_STATS_EN adds saturating stall/flush counters
module pipe_stage_reg #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] RST_VAL    = '0,
  parameter logic [WIDTH-1:0] BUBBLE_VAL = '0,
  parameter int               CNT_W      = 16
) (
  input logic              clk,
  input logic              rst,
  pipe_stage_reg_if.slave  io_stage
);
  logic [WIDTH-1:0] r_q;
  logic             r_valid;
  always_ff @(posedge clk)
    if (rst) begin
      r_q     <= RST_VAL;
      r_valid <= 1'b0;
    end else if (io_stage.flush) begin
      r_q     <= BUBBLE_VAL;
      r_valid <= 1'b0;
    end else if (!io_stage.stall) begin
      r_q     <= io_stage.d;
      r_valid <= io_stage.valid_in;
    end
  assign io_stage.q         = r_q;
  assign io_stage.valid_out = r_valid;
`ifdef PIPE_REG_STATS_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  always_ff @(posedge clk)
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!io_stage.flush && io_stage.stall && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (io_stage.flush && r_valid && !(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  assign io_stage.stall_cnt = r_stall_cnt;
  assign io_stage.flush_cnt = r_flush_cnt;
`else
  assign io_stage.stall_cnt = '0;
  assign io_stage.flush_cnt = '0;
`endif
endmodule
